// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and frame byte placement for the boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        RUN,
        ERROR
    } state_t;

    // Frame words are big-endian: the first byte on the wire is the upper half.
    localparam int HI_LSB = 8;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: latches the high byte, then emits a 16-bit word with a one-cycle valid
// when the low byte arrives.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  data,
    output logic [15:0] word,
    output logic        valid
);

    logic [7:0] hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= lo_en;
            if (hi_en)
                hi <= data;
            if (lo_en) begin
                word[HI_LSB +: 8] <= hi;
                word[LO_LSB +: 8] <= data;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a counted, XOR-checksummed byte frame, writes the packed words
// to memory and releases the CPU only when the checksum matches.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = 128,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_in,
    output logic              cpu_run,
    output logic              boot_err
);

    localparam logic [15:0] MAX_N = 16'(MEM_WORDS);

    state_t      state, nxt;
    logic [15:0] cnt, idx, n;
    logic [7:0]  csum;
    logic        fire;

    assign fire = rx_valid && rx_ready;
    assign n    = {cnt[15:8], rx_data};

    always_comb begin
        nxt = state;
        if (fire)
            case (state)
                CNT_HI:  nxt = CNT_LO;
                CNT_LO:  nxt = (n > MAX_N) ? ERROR : (n == 16'd0) ? CHECK : DATA_HI;
                DATA_HI: nxt = DATA_LO;
                DATA_LO: nxt = (idx + 16'd1 == cnt) ? CHECK : DATA_HI;
                CHECK:   nxt = (rx_data == csum) ? RUN : ERROR;
                default: nxt = state;
            endcase
    end

    // Outputs follow the next state so RUN/ERROR drop rx_ready on the entering edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CNT_HI;
            rx_ready <= 1'b0;
            cpu_run  <= 1'b0;
            boot_err <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
            idx      <= '0;
            csum     <= '0;
        end else begin
            state    <= nxt;
            rx_ready <= (nxt != RUN) && (nxt != ERROR);
            cpu_run  <= (nxt == RUN);
            boot_err <= (nxt == ERROR);
            if (fire)
                case (state)
                    CNT_HI:  cnt[15:8] <= rx_data;
                    CNT_LO:  cnt[7:0]  <= rx_data;
                    DATA_HI: csum      <= csum ^ rx_data;
                    DATA_LO: begin
                        csum     <= csum ^ rx_data;
                        mem_addr <= ADDR_W'(START_ADDR) + ADDR_W'(idx);
                        idx      <= idx + 16'd1;
                    end
                    default: ;
                endcase
        end
    end

    byte_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .hi_en (fire && state == DATA_HI),
        .lo_en (fire && state == DATA_LO),
        .data  (rx_data),
        .word  (mem_in),
        .valid (mem_we)
    );

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized frames checked against a word-list model of the boot
// protocol, with a bench memory muxed between loader and a CPU stand-in.
module tb_boot_loader;

    localparam int ADDR_W     = 15;
    localparam int MEM_WORDS  = 128;
    localparam int START_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready, mem_we, cpu_run, boot_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_in;

    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [15:0]       cpu_data = '0;
    logic              clr = 1'b0;
    logic              prev_we = 1'b0;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] w [0:299];
    int          vectors = 0, errs = 0, we_cnt = 0, dbl = 0;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .START_ADDR(START_ADDR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .cpu_run  (cpu_run),
        .boot_err (boot_err)
    );

    // Memory port mux: the loader owns memory until cpu_run, then the CPU does.
    always @(posedge clk) begin
        prev_we <= mem_we;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_we && prev_we) dbl <= dbl + 1;
        if (clr)
            for (int i = 0; i < 512; i++) mem[i] <= 16'hDEAD;
        else if (!cpu_run && mem_we)
            mem[mem_addr] <= mem_in;
        else if (cpu_run && cpu_we)
            mem[cpu_addr] <= cpu_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_in", mem_in, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_boot_err", boot_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", rx_ready, 1);
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Entered and left at a falling edge; the byte transfers on the rising edge in between.
    task automatic send(input logic [7:0] b, input int max_gap);
        int k;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (!rx_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("rx_ready_timeout", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [7:0] flip, input int max_gap, input bit do_clr);
        logic [15:0] nn;
        logic [7:0]  ck;
        int          base, exp_we;
        bit          ok;
        nn = n[15:0];
        if (do_clr) clear_mem();
        do_reset();
        base = we_cnt;
        ck = 8'h00;
        send(nn[15:8], max_gap);
        send(nn[7:0], max_gap);
        if (n <= MEM_WORDS) begin
            for (int i = 0; i < n; i++) begin
                send(w[i][15:8], max_gap);
                send(w[i][7:0], max_gap);
                ck = ck ^ w[i][15:8] ^ w[i][7:0];
            end
            send(ck ^ flip, max_gap);
        end
        ok = (n <= MEM_WORDS) && (flip == 8'h00);
        exp_we = (n <= MEM_WORDS) ? n : 0;
        repeat (2) @(negedge clk);
        check("cpu_run", cpu_run, ok);
        check("boot_err", boot_err, !ok);
        check("rx_ready_final", rx_ready, 0);
        check("we_count", we_cnt - base, exp_we);
        for (int i = 0; i < exp_we; i++)
            check($sformatf("mem[%0d]", START_ADDR + i), mem[START_ADDR + i], w[i]);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check("we_after_end", we_cnt - base, exp_we);
        check("cpu_run_hold", cpu_run, ok);
        check("boot_err_hold", boot_err, !ok);
    endtask

    initial begin
        int n;
        logic [7:0] flip;
        w[0] = 16'hF10A;
        w[1] = 16'hF20A;
        w[2] = 16'hD120;
        run_frame(3, 8'h00, 0, 1);
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_addr = 15'd5;
        cpu_data = 16'h0014;
        @(negedge clk);
        cpu_we = 1'b0;
        check("cpu_store", mem[5], 16'h0014);
        run_frame(3, 8'hF2, 0, 1);
        run_frame(129, 8'h00, 0, 1);
        run_frame(0, 8'h00, 0, 1);
        run_frame(0, 8'h01, 0, 1);
        for (int r = 0; r < 3; r++) run_frame(3, 8'h00, 5, 1);
        // Abort a frame after four data bytes, then load a different image from scratch.
        clear_mem();
        do_reset();
        send(8'h00, 0); send(8'h03, 0);
        send(8'hF1, 0); send(8'h0A, 0); send(8'hF2, 0); send(8'h0A, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_mem_we", mem_we, 0);
        for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
        run_frame(3, 8'h00, 0, 0);
        for (int r = 0; r < 14; r++) begin
            n = (r == 0) ? MEM_WORDS : (r % 5 == 4) ? int'($urandom_range(129, 300)) : int'($urandom_range(1, 40));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < 300; i++) w[i] = 16'($urandom);
            run_frame(n, flip, $urandom_range(0, 3), 1);
        end
        check("single_cycle_we", dbl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
